mem_arbiter: RTL and testbench

- Shares one backing-memory port between two cache_direct-style clients: client 0 is the instruction cache, client 1 is the data cache.
- Each client has a write-back (evict) channel and a fill (read) channel, both using level req / one-cycle ack.
- The arbiter serializes all traffic: one memory transaction at a time, round-robin between clients, evict-before-fill within a client.
- Sits between the two L1 caches and the memory model.

---
 rtl/mem_arbiter_pkg.sv | 35 +++
 rtl/mem_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and helpers for the two-client backing-memory arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_DONE = 2'd2
  } arb_state_e;

  typedef enum logic {
    CH_READ  = 1'b0,
    CH_WRITE = 1'b1
  } arb_chan_e;

  localparam logic ARB_ICACHE = 1'b0;
  localparam logic ARB_DCACHE = 1'b1;

  // Two-way round robin: the client that did not go last wins if it is pending.
  function automatic logic rr_pick(input logic [1:0] pend, input logic last);
    logic other;
    other = ~last;
    if (pend[other]) begin
      return other;
    end else begin
      return last;
    end
  endfunction

  function automatic logic [31:0] line_align(input logic [31:0] addr, input int wb);
    logic [31:0] mask;
    mask = ~((32'd1 << wb) - 32'd1);
    return addr & mask;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Serializes I-cache (client 0) and D-cache (client 1) evict/fill traffic onto
// one memory port: round-robin between clients, evict before fill within one.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int WIDTH = 128
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             c0_write_req,
  input  logic [31:0]      c0_write_addr,
  input  logic [WIDTH-1:0] c0_write_data,
  output logic             c0_write_ack,
  input  logic             c0_read_req,
  input  logic [31:0]      c0_read_addr,
  output logic [WIDTH-1:0] c0_read_data,
  output logic             c0_read_ack,
  input  logic             c1_write_req,
  input  logic [31:0]      c1_write_addr,
  input  logic [WIDTH-1:0] c1_write_data,
  output logic             c1_write_ack,
  input  logic             c1_read_req,
  input  logic [31:0]      c1_read_addr,
  output logic [WIDTH-1:0] c1_read_data,
  output logic             c1_read_ack,
  output logic             mem_req,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ack,
  output logic             owner
);

  localparam int WB = $clog2(WIDTH) - 3;

  arb_state_e       state_r, state_s;
  arb_chan_e        chan_r, chan_s;
  logic             last_r, last_s;
  logic             owner_r, owner_s;
  logic             mem_req_r, mem_req_s;
  logic             mem_we_r, mem_we_s;
  logic [31:0]      mem_addr_r, mem_addr_s;
  logic [WIDTH-1:0] mem_wdata_r, mem_wdata_s;
  logic             c0_write_ack_r, c0_write_ack_s;
  logic             c0_read_ack_r, c0_read_ack_s;
  logic             c1_write_ack_r, c1_write_ack_s;
  logic             c1_read_ack_r, c1_read_ack_s;
  logic [WIDTH-1:0] c0_read_data_r, c0_read_data_s;
  logic [WIDTH-1:0] c1_read_data_r, c1_read_data_s;

  logic [1:0]       pend_s;
  logic             win_s;
  logic             win_wr_s;
  logic [31:0]      sel_addr_s;
  logic [WIDTH-1:0] sel_wdata_s;

  // Winner and its channel/address/data selection for the next grant.
  always_comb begin
    pend_s = {c1_write_req | c1_read_req, c0_write_req | c0_read_req};
    win_s  = rr_pick(pend_s, last_r);
    if (win_s == ARB_DCACHE) begin
      win_wr_s    = c1_write_req;
      sel_addr_s  = c1_write_req ? c1_write_addr : c1_read_addr;
      sel_wdata_s = c1_write_data;
    end else begin
      win_wr_s    = c0_write_req;
      sel_addr_s  = c0_write_req ? c0_write_addr : c0_read_addr;
      sel_wdata_s = c0_write_data;
    end
  end

  // Next-state and next-output logic of the IDLE/BUSY/DONE controller.
  always_comb begin
    state_s        = state_r;
    chan_s         = chan_r;
    last_s         = last_r;
    owner_s        = owner_r;
    mem_req_s      = mem_req_r;
    mem_we_s       = mem_we_r;
    mem_addr_s     = mem_addr_r;
    mem_wdata_s    = mem_wdata_r;
    c0_write_ack_s = 1'b0;
    c0_read_ack_s  = 1'b0;
    c1_write_ack_s = 1'b0;
    c1_read_ack_s  = 1'b0;
    c0_read_data_s = c0_read_data_r;
    c1_read_data_s = c1_read_data_r;

    case (state_r)
      ARB_IDLE: begin
        if (|pend_s) begin
          owner_s    = win_s;
          chan_s     = arb_chan_e'(win_wr_s);
          mem_req_s  = 1'b1;
          mem_we_s   = win_wr_s;
          mem_addr_s = line_align(sel_addr_s, WB);
          if (win_wr_s) begin
            mem_wdata_s = sel_wdata_s;
          end else begin
            mem_wdata_s = mem_wdata_r;
          end
          state_s = ARB_BUSY;
        end else begin
          state_s = ARB_IDLE;
        end
      end

      ARB_BUSY: begin
        if (mem_ack) begin
          mem_req_s = 1'b0;
          last_s    = owner_r;
          state_s   = ARB_DONE;
          if (chan_r == CH_WRITE) begin
            if (owner_r == ARB_DCACHE) begin
              c1_write_ack_s = 1'b1;
            end else begin
              c0_write_ack_s = 1'b1;
            end
          end else begin
            if (owner_r == ARB_DCACHE) begin
              c1_read_ack_s  = 1'b1;
              c1_read_data_s = mem_rdata;
            end else begin
              c0_read_ack_s  = 1'b1;
              c0_read_data_s = mem_rdata;
            end
          end
        end else begin
          state_s = ARB_BUSY;
        end
      end

      // One dead cycle so the acked client's req has dropped before re-arbitration.
      ARB_DONE: begin
        state_s = ARB_IDLE;
      end

      default: begin
        state_s   = ARB_IDLE;
        mem_req_s = 1'b0;
      end
    endcase
  end

  // State and registered-output flops; reset abandons any transaction silently.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r        <= ARB_IDLE;
      chan_r         <= CH_READ;
      last_r         <= ARB_DCACHE;
      owner_r        <= 1'b0;
      mem_req_r      <= 1'b0;
      mem_we_r       <= 1'b0;
      mem_addr_r     <= 32'd0;
      mem_wdata_r    <= {WIDTH{1'b0}};
      c0_write_ack_r <= 1'b0;
      c0_read_ack_r  <= 1'b0;
      c1_write_ack_r <= 1'b0;
      c1_read_ack_r  <= 1'b0;
      c0_read_data_r <= {WIDTH{1'b0}};
      c1_read_data_r <= {WIDTH{1'b0}};
    end else begin
      state_r        <= state_s;
      chan_r         <= chan_s;
      last_r         <= last_s;
      owner_r        <= owner_s;
      mem_req_r      <= mem_req_s;
      mem_we_r       <= mem_we_s;
      mem_addr_r     <= mem_addr_s;
      mem_wdata_r    <= mem_wdata_s;
      c0_write_ack_r <= c0_write_ack_s;
      c0_read_ack_r  <= c0_read_ack_s;
      c1_write_ack_r <= c1_write_ack_s;
      c1_read_ack_r  <= c1_read_ack_s;
      c0_read_data_r <= c0_read_data_s;
      c1_read_data_r <= c1_read_data_s;
    end
  end

  assign c0_write_ack = c0_write_ack_r;
  assign c0_read_ack  = c0_read_ack_r;
  assign c1_write_ack = c1_write_ack_r;
  assign c1_read_ack  = c1_read_ack_r;
  assign c0_read_data = c0_read_data_r;
  assign c1_read_data = c1_read_data_r;
  assign mem_req      = mem_req_r;
  assign mem_we       = mem_we_r;
  assign mem_addr     = mem_addr_r;
  assign mem_wdata    = mem_wdata_r;
  assign owner        = owner_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a simple acking memory model.
module tb_mem_arbiter;

  localparam int W = 128;

  logic         clk;
  logic         reset;
  logic         c0_write_req, c0_read_req, c1_write_req, c1_read_req;
  logic [31:0]  c0_write_addr, c0_read_addr, c1_write_addr, c1_read_addr;
  logic [W-1:0] c0_write_data, c1_write_data;
  logic         c0_write_ack, c0_read_ack, c1_write_ack, c1_read_ack;
  logic [W-1:0] c0_read_data, c1_read_data;
  logic         mem_req, mem_we, mem_ack, owner;
  logic [31:0]  mem_addr;
  logic [W-1:0] mem_wdata, mem_rdata;

  int checks;
  int errors;

  // Memory model / monitor state, only touched from the stimulus process.
  int           cyc;
  bit           mem_auto;
  int           mem_dly;
  int           wait_cnt;
  bit           prev_req;
  int           last_mack_cyc;
  int           min_gap;
  int           cnt_w0, cnt_r0, cnt_w1, cnt_r1;
  int           multi_ack;
  int           g_n;
  logic         g_owner [0:15];
  logic         g_we    [0:15];
  logic [31:0]  g_addr  [0:15];
  logic [W-1:0] g_wdata [0:15];

  mem_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .c0_write_req(c0_write_req), .c0_write_addr(c0_write_addr),
    .c0_write_data(c0_write_data), .c0_write_ack(c0_write_ack),
    .c0_read_req(c0_read_req), .c0_read_addr(c0_read_addr),
    .c0_read_data(c0_read_data), .c0_read_ack(c0_read_ack),
    .c1_write_req(c1_write_req), .c1_write_addr(c1_write_addr),
    .c1_write_data(c1_write_data), .c1_write_ack(c1_write_ack),
    .c1_read_req(c1_read_req), .c1_read_addr(c1_read_addr),
    .c1_read_data(c1_read_data), .c1_read_ack(c1_read_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .owner(owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One negedge step: log grants, count acks, drop acked reqs, run the memory.
  task automatic cycle();
    int n;
    @(negedge clk);
    cyc = cyc + 1;
    mem_ack = 1'b0;
    if (mem_req && !prev_req) begin
      if (g_n < 16) begin
        g_owner[g_n] = owner;
        g_we[g_n]    = mem_we;
        g_addr[g_n]  = mem_addr;
        g_wdata[g_n] = mem_wdata;
      end
      g_n = g_n + 1;
      if (cyc - last_mack_cyc < min_gap) min_gap = cyc - last_mack_cyc;
    end
    prev_req = mem_req;
    n = 0;
    if (c0_write_ack) begin cnt_w0++; n++; c0_write_req = 1'b0; end
    if (c0_read_ack)  begin cnt_r0++; n++; c0_read_req  = 1'b0; end
    if (c1_write_ack) begin cnt_w1++; n++; c1_write_req = 1'b0; end
    if (c1_read_ack)  begin cnt_r1++; n++; c1_read_req  = 1'b0; end
    if (n > 1) multi_ack++;
    if (mem_auto && mem_req) begin
      if (wait_cnt >= mem_dly) begin
        mem_ack = 1'b1;
        last_mack_cyc = cyc;
        wait_cnt = 0;
      end else begin
        wait_cnt = wait_cnt + 1;
      end
    end else begin
      wait_cnt = 0;
    end
  endtask

  task automatic test_reset();
    checks++;
    if (mem_req !== 1'b0 || mem_we !== 1'b0 || owner !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: req/we/owner=%b%b%b required 000", mem_req, mem_we, owner);
    end
    checks++;
    if (mem_addr !== 32'd0 || mem_wdata !== {W{1'b0}}) begin
      errors++;
      $display("FAIL reset_bus: addr=%h wdata=%h required 0", mem_addr, mem_wdata);
    end
    checks++;
    if ({c0_write_ack, c0_read_ack, c1_write_ack, c1_read_ack} !== 4'b0000 ||
        c0_read_data !== {W{1'b0}} || c1_read_data !== {W{1'b0}}) begin
      errors++;
      $display("FAIL reset_acks: acks=%b%b%b%b required 0000 with zero read data",
               c0_write_ack, c0_read_ack, c1_write_ack, c1_read_ack);
    end
  endtask

  task automatic test_single_read();
    int req_cyc, ack_cyc, mack_cyc;
    logic [W-1:0] exp_data;
    exp_data = {4{32'hDEADBEEF}};
    mem_rdata = exp_data;
    mem_dly = 3;
    g_n = 0;
    c0_read_addr = 32'h0000_1234;
    c0_read_req = 1'b1;
    req_cyc = cyc;
    ack_cyc = -1;
    mack_cyc = -1;
    for (int i = 0; i < 30 && ack_cyc < 0; i++) begin
      cycle();
      if (mem_ack) mack_cyc = cyc;
      if (c0_read_ack) begin
        ack_cyc = cyc;
        checks++;
        if (c0_read_data !== exp_data) begin
          errors++;
          $display("FAIL rd_data: got %h required %h", c0_read_data, exp_data);
        end
      end
    end
    checks++;
    if (ack_cyc < 0) begin
      errors++;
      $display("FAIL rd_timeout: c0_read_ack never seen, required within 30 cycles");
    end
    checks++;
    if (g_n !== 1 || g_addr[0] !== 32'h0000_1230 || g_we[0] !== 1'b0 || g_owner[0] !== 1'b0) begin
      errors++;
      $display("FAIL rd_grant: n=%0d addr=%h we=%b owner=%b required 1 00001230 0 0",
               g_n, g_addr[0], g_we[0], g_owner[0]);
    end
    checks++;
    if (ack_cyc - mack_cyc !== 1) begin
      errors++;
      $display("FAIL rd_ack_latency: got %0d cycles required 1", ack_cyc - mack_cyc);
    end
    cycle();
    cycle();
    checks++;
    if (cnt_r0 !== 1 || c0_read_data !== exp_data || owner !== 1'b0) begin
      errors++;
      $display("FAIL rd_pulse_hold: pulses=%0d data=%h owner=%b required 1 held 0",
               cnt_r0, c0_read_data, owner);
    end
  endtask

  task automatic test_write_before_read();
    int wack_cyc, rack_cyc;
    logic [W-1:0] exp_rd;
    exp_rd = {4{32'h0123_4567}};
    mem_rdata = exp_rd;
    mem_dly = 1;
    g_n = 0;
    c1_write_addr = 32'h0000_2000;
    c1_write_data = {16{8'hA5}};
    c1_read_addr  = 32'h0000_3004;
    c1_write_req = 1'b1;
    c1_read_req  = 1'b1;
    wack_cyc = -1;
    rack_cyc = -1;
    for (int i = 0; i < 40 && rack_cyc < 0; i++) begin
      cycle();
      if (c1_write_ack) wack_cyc = cyc;
      if (c1_read_ack)  rack_cyc = cyc;
    end
    cycle();
    checks++;
    if (g_n !== 2 || g_we[0] !== 1'b1 || g_addr[0] !== 32'h0000_2000 ||
        g_wdata[0] !== {16{8'hA5}} || g_owner[0] !== 1'b1) begin
      errors++;
      $display("FAIL wr_first_grant: n=%0d we=%b addr=%h owner=%b required 2 1 00002000 1",
               g_n, g_we[0], g_addr[0], g_owner[0]);
    end
    checks++;
    if (g_we[1] !== 1'b0 || g_addr[1] !== 32'h0000_3000 || g_owner[1] !== 1'b1) begin
      errors++;
      $display("FAIL rd_second_grant: we=%b addr=%h owner=%b required 0 00003000 1",
               g_we[1], g_addr[1], g_owner[1]);
    end
    checks++;
    if (wack_cyc < 0 || rack_cyc <= wack_cyc || cnt_w1 !== 1 || cnt_r1 !== 1) begin
      errors++;
      $display("FAIL wr_rd_acks: wack@%0d rack@%0d counts %0d/%0d required write first, 1/1",
               wack_cyc, rack_cyc, cnt_w1, cnt_r1);
    end
    checks++;
    if (c1_read_data !== exp_rd || multi_ack !== 0) begin
      errors++;
      $display("FAIL wr_rd_data: data=%h overlaps=%0d required %h 0", c1_read_data, multi_ack, exp_rd);
    end
  endtask

  task automatic test_round_robin();
    int n0, n1, base;
    logic exp_own [0:3];
    logic [31:0] exp_adr [0:3];
    exp_own[0] = 1'b0; exp_own[1] = 1'b1; exp_own[2] = 1'b0; exp_own[3] = 1'b1;
    exp_adr[0] = 32'h100; exp_adr[1] = 32'h200; exp_adr[2] = 32'h100; exp_adr[3] = 32'h200;
    mem_rdata = {4{32'hCAFE_F00D}};
    mem_dly = 0;
    g_n = 0;
    min_gap = 1000;
    base = cnt_r0 + cnt_r1;
    c0_read_addr = 32'h0000_0100;
    c1_read_addr = 32'h0000_0204;
    c0_read_req = 1'b1;
    c1_read_req = 1'b1;
    n0 = 1;
    n1 = 1;
    for (int i = 0; i < 60 && (cnt_r0 + cnt_r1 - base) < 4; i++) begin
      cycle();
      if (!c0_read_req && n0 < 2) begin c0_read_req = 1'b1; n0++; end
      if (!c1_read_req && n1 < 2) begin c1_read_req = 1'b1; n1++; end
    end
    cycle();
    checks++;
    if (g_n !== 4) begin
      errors++;
      $display("FAIL rr_count: grants=%0d required 4", g_n);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (g_owner[k] !== exp_own[k] || g_addr[k] !== exp_adr[k]) begin
        errors++;
        $display("FAIL rr_order[%0d]: owner=%b addr=%h required %b %h",
                 k, g_owner[k], g_addr[k], exp_own[k], exp_adr[k]);
      end
    end
    checks++;
    if (min_gap < 2 || multi_ack !== 0) begin
      errors++;
      $display("FAIL rr_spacing: min gap=%0d overlaps=%0d required >=2 and 0", min_gap, multi_ack);
    end
  endtask

  task automatic test_reset_mid_busy();
    int w1_base;
    bit seen;
    mem_dly = 20;
    c1_write_addr = 32'h0000_4008;
    c1_write_data = {4{32'h600D_F00D}};
    c1_write_req = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      cycle();
      if (mem_req) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL rst_grant_timeout: mem_req never rose, required within 10 cycles");
    end
    cycle();
    cycle();
    w1_base = cnt_w1;
    #2 reset = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || owner !== 1'b0 || mem_we !== 1'b0 || c1_write_ack !== 1'b0) begin
      errors++;
      $display("FAIL rst_async: req=%b owner=%b we=%b ack=%b required 0 0 0 0",
               mem_req, owner, mem_we, c1_write_ack);
    end
    cycle();
    cycle();
    g_n = 0;
    #2 reset = 1'b1;
    mem_dly = 2;
    for (int i = 0; i < 20 && cnt_w1 == w1_base; i++) cycle();
    cycle();
    cycle();
    checks++;
    if (g_n !== 1 || g_addr[0] !== 32'h0000_4000 || g_we[0] !== 1'b1 || g_owner[0] !== 1'b1 ||
        g_wdata[0] !== {4{32'h600D_F00D}}) begin
      errors++;
      $display("FAIL rst_regrant: n=%0d addr=%h we=%b owner=%b required 1 00004000 1 1",
               g_n, g_addr[0], g_we[0], g_owner[0]);
    end
    checks++;
    if (cnt_w1 - w1_base !== 1) begin
      errors++;
      $display("FAIL rst_ack_count: got %0d ack cycles required 1", cnt_w1 - w1_base);
    end
  endtask

  task automatic test_spurious_ack();
    int base;
    cycle();
    cycle();
    g_n = 0;
    base = cnt_w0 + cnt_r0 + cnt_w1 + cnt_r1;
    mem_ack = 1'b1;
    cycle();
    cycle();
    cycle();
    checks++;
    if (mem_req !== 1'b0 || g_n !== 0 || (cnt_w0 + cnt_r0 + cnt_w1 + cnt_r1) !== base) begin
      errors++;
      $display("FAIL spur_idle: req=%b grants=%0d new acks=%0d required 0 0 0",
               mem_req, g_n, cnt_w0 + cnt_r0 + cnt_w1 + cnt_r1 - base);
    end
    mem_dly = 0;
    c0_write_addr = 32'h0000_5010;
    c0_write_data = {8{16'hBEEF}};
    c0_write_req = 1'b1;
    base = cnt_w0;
    for (int i = 0; i < 20 && cnt_w0 == base; i++) cycle();
    cycle();
    checks++;
    if (cnt_w0 - base !== 1 || g_n !== 1 || g_addr[0] !== 32'h0000_5010 || g_we[0] !== 1'b1 ||
        g_owner[0] !== 1'b0 || g_wdata[0] !== {8{16'hBEEF}}) begin
      errors++;
      $display("FAIL spur_next_req: acks=%0d n=%0d addr=%h we=%b owner=%b required 1 1 00005010 1 0",
               cnt_w0 - base, g_n, g_addr[0], g_we[0], g_owner[0]);
    end
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0;
    mem_auto = 1'b1; mem_dly = 0; wait_cnt = 0; prev_req = 1'b0;
    last_mack_cyc = -1000; min_gap = 1000;
    cnt_w0 = 0; cnt_r0 = 0; cnt_w1 = 0; cnt_r1 = 0; multi_ack = 0; g_n = 0;
    reset = 1'b0;
    c0_write_req = 1'b0; c0_read_req = 1'b0; c1_write_req = 1'b0; c1_read_req = 1'b0;
    c0_write_addr = 32'd0; c0_read_addr = 32'd0; c1_write_addr = 32'd0; c1_read_addr = 32'd0;
    c0_write_data = {W{1'b0}}; c1_write_data = {W{1'b0}};
    mem_ack = 1'b0; mem_rdata = {W{1'b0}};
    #12;
    test_reset();
    cycle();
    #2 reset = 1'b1;
    cycle();
    test_single_read();
    test_write_before_read();
    test_round_robin();
    test_reset_mid_busy();
    test_spurious_ack();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
